// File: rtl/shift_up.sv
// Up-counting LED pattern generator for the reconfigurable partition, with a
// decouple request/acknowledge handshake. Define SHIFT_UP_GRAY_EN for Gray-coded count_out.
module shift_up #(
  parameter int          PRESCALE_W = 25,
  parameter logic [3:0]  RESET_VAL  = 4'b0000,
  parameter logic [3:0]  STEP       = 4'd1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       decouple_req,
  output logic       decouple_ack,
  output logic [3:0] count_out,
  output logic       tick,
  output logic       wrap
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_FREEZE,
    ST_DECOUPLED,
    ST_RESUME
  } state_t;

  localparam logic [3:0]            MARKER  = 4'b1010;
  localparam logic [PRESCALE_W-1:0] PRE_ONE = PRESCALE_W'(1);
  localparam logic [PRESCALE_W-1:0] PRE_MAX = '1;

  // NOTE: no reset on purpose; this marker only holds its value if the
  // configuration/GSR init restored it, so it qualifies every step.
  logic [3:0] count_en_q = MARKER;

  state_t                  state_q, state_d;
  logic [PRESCALE_W-1:0]   pre_q, pre_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [3:0]              count_out_q;
  logic                    tick_q, tick_d;
  logic                    wrap_q, wrap_d;
  logic                    ack_q, ack_d;
  logic [4:0]              sum;
  logic                    marker_ok;

  // Binary count as presented on the LEDs.
  function automatic logic [3:0] present(input logic [3:0] bin);
`ifdef SHIFT_UP_GRAY_EN
    return bin ^ {1'b0, bin[3:1]};
`else
    return bin;
`endif
  endfunction

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    pre_d     = pre_q;
    cnt_d     = cnt_q;
    tick_d    = 1'b0;
    wrap_d    = 1'b0;
    sum       = {1'b0, cnt_q} + {1'b0, STEP};
    marker_ok = (count_en_q == MARKER);

    case (state_q)
      ST_RUN: begin
        // A freeze request wins over load and step in the same cycle.
        if (decouple_req) begin
          state_d = ST_FREEZE;
        end else if (load) begin
          cnt_d = load_val;
          pre_d = '0;
        end else if (en) begin
          pre_d = pre_q + PRE_ONE;
          if (pre_q == PRE_MAX && marker_ok) begin
            cnt_d  = sum[3:0];
            tick_d = 1'b1;
            wrap_d = sum[4];
          end
        end
      end
      ST_FREEZE: begin
        state_d = ST_DECOUPLED;
      end
      ST_DECOUPLED: begin
        if (!decouple_req) state_d = ST_RESUME;
      end
      ST_RESUME: begin
        pre_d   = '0;
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    ack_d = (state_d == ST_DECOUPLED);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      pre_q       <= '0;
      cnt_q       <= RESET_VAL;
      count_out_q <= present(RESET_VAL);
      tick_q      <= 1'b0;
      wrap_q      <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pre_q       <= pre_d;
      cnt_q       <= cnt_d;
      count_out_q <= present(cnt_d);
      tick_q      <= tick_d;
      wrap_q      <= wrap_d;
      ack_q       <= ack_d;
    end
  end

  assign count_out    = count_out_q;
  assign tick         = tick_q;
  assign wrap         = wrap_q;
  assign decouple_ack = ack_q;

endmodule

// File: tb/tb_shift_up.sv
// Directed bench for shift_up with a reference model feeding an expected-value
// queue; also checks the Gray sequence when SHIFT_UP_GRAY_EN is defined.
module tb_shift_up;

  localparam int PW   = 3;
  localparam int PMAX = (1 << PW) - 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       load;
  logic [3:0] load_val;
  logic       decouple_req;
  logic       decouple_ack;
  logic [3:0] count_out;
  logic       tick;
  logic       wrap;

  typedef struct {
    logic [3:0] cnt;
    logic       tick;
    logic       wrap;
    logic       ack;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_err    = 0;
  int ticks    = 0;
  int wraps    = 0;

  // Reference model: 0 run, 1 freeze, 2 decoupled, 3 resume
  int   m_phase;
  int   m_pre;
  int   m_cnt;
  logic m_tick, m_wrap, m_ack;

  shift_up #(.PRESCALE_W(PW)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .load         (load),
    .load_val     (load_val),
    .decouple_req (decouple_req),
    .decouple_ack (decouple_ack),
    .count_out    (count_out),
    .tick         (tick),
    .wrap         (wrap)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  function automatic logic [3:0] present(input int bin);
    logic [3:0] b;
    b = 4'(bin);
`ifdef SHIFT_UP_GRAY_EN
    return b ^ (b >> 1);
`else
    return b;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_pre   = 0;
    m_cnt   = 0;
    m_tick  = 1'b0;
    m_wrap  = 1'b0;
    m_ack   = 1'b0;
  endtask

  // Drive one cycle, predict, then compare the DUT against the popped prediction.
  task automatic cycle(input logic e, input logic ld, input logic [3:0] lv, input logic rq);
    exp_t ex;
    en = e; load = ld; load_val = lv; decouple_req = rq;
    m_tick = 1'b0;
    m_wrap = 1'b0;
    case (m_phase)
      0: begin
        if (rq) m_phase = 1;
        else if (ld) begin
          m_cnt = int'(lv);
          m_pre = 0;
        end else if (e) begin
          if (m_pre == PMAX) begin
            m_pre  = 0;
            m_tick = 1'b1;
            m_wrap = (m_cnt + 1 > 15);
            m_cnt  = (m_cnt + 1) % 16;
          end else m_pre = m_pre + 1;
        end
      end
      1: m_phase = 2;
      2: if (!rq) m_phase = 3;
      default: begin
        m_pre   = 0;
        m_phase = 0;
      end
    endcase
    m_ack = (m_phase == 2);
    sb.push_back('{cnt: present(m_cnt), tick: m_tick, wrap: m_wrap, ack: m_ack});

    @(posedge clk);
    #1;
    ex = sb.pop_front();
    check("count_out", count_out, ex.cnt);
    check("tick", tick, ex.tick);
    check("wrap", wrap, ex.wrap);
    check("decouple_ack", decouple_ack, ex.ack);
    if (tick === 1'b1) ticks++;
    if (wrap === 1'b1) wraps++;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    en = 1'b0; load = 1'b0; load_val = 4'h0; decouple_req = 1'b0;
    model_reset();
    #1;
    check("rst_count", count_out, present(0));
    check("rst_tick", tick, 1'b0);
    check("rst_wrap", wrap, 1'b0);
    check("rst_ack", decouple_ack, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  logic [3:0] seq [3];

  initial begin
    // Count up from reset
    do_reset();
    ticks = 0; wraps = 0;
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 4'h0, 1'b0);
    check("step8_count", count_out, present(1));
    check("step8_tick", tick, 1'b1);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 4'h0, 1'b0);
    check("step16_count", count_out, present(2));
    check("first_ticks", 32'(ticks), 32'd2);
    check("first_wraps", 32'(wraps), 32'd0);

    // Load E and wrap through F -> 0
    cycle(1'b1, 1'b1, 4'hE, 1'b0);
    check("load_e", count_out, present(14));
    ticks = 0; wraps = 0;
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 4'h0, 1'b0);
    check("wrap_count", count_out, present(0));
    check("wrap_once", 32'(wraps), 32'd1);
    check("wrap_ticks", 32'(ticks), 32'd2);

    // Load coincident with a step: load wins
    for (int i = 0; i < PMAX; i++) cycle(1'b1, 1'b0, 4'h0, 1'b0);
    cycle(1'b1, 1'b1, 4'hE, 1'b0);
    check("ld_step_count", count_out, present(14));
    check("ld_step_tick", tick, 1'b0);

    // Enable low holds the prescaler
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 4'h0, 1'b0);

    // Decouple request at prescaler = 5
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 4'h0, 1'b0);
    cycle(1'b1, 1'b0, 4'h0, 1'b1);
    check("ack_not_yet", decouple_ack, 1'b0);
    cycle(1'b1, 1'b0, 4'h0, 1'b1);
    check("ack_rise", decouple_ack, 1'b1);
    ticks = 0;
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'(i % 2), 4'h3, 1'b1);
    check("frozen_count", count_out, present(14));
    check("frozen_ticks", 32'(ticks), 32'd0);
    cycle(1'b1, 1'b0, 4'h0, 1'b0);
    check("ack_fall", decouple_ack, 1'b0);
    cycle(1'b1, 1'b0, 4'h0, 1'b0);
    ticks = 0;
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 4'h0, 1'b0);
    check("resume_no_early_tick", 32'(ticks), 32'd0);
    cycle(1'b1, 1'b0, 4'h0, 1'b0);
    check("resume_tick", tick, 1'b1);
    check("resume_count", count_out, present(15));

    // Request dropped during FREEZE: ack pulses for one cycle
    cycle(1'b1, 1'b0, 4'h0, 1'b1);
    cycle(1'b1, 1'b0, 4'h0, 1'b0);
    check("drop_ack_pulse", decouple_ack, 1'b1);
    cycle(1'b1, 1'b0, 4'h0, 1'b0);
    check("drop_ack_low", decouple_ack, 1'b0);
    cycle(1'b1, 1'b0, 4'h0, 1'b0);

    // Request on the step cycle suppresses the step
    for (int i = 0; i < PMAX; i++) cycle(1'b1, 1'b0, 4'h0, 1'b0);
    cycle(1'b1, 1'b0, 4'h0, 1'b1);
    check("supp_tick", tick, 1'b0);
    check("supp_count", count_out, present(15));
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 4'h0, 1'b1);
    check("supp_hold_count", count_out, present(15));
    check("supp_ack", decouple_ack, 1'b1);

    // Asynchronous reset while DECOUPLED, between clock edges
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check("async_count", count_out, present(0));
    check("async_ack", decouple_ack, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    decouple_req = 1'b0;
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 4'h0, 1'b0);
    check("after_async_count", count_out, present(1));

    // Presented sequence over three steps from reset
`ifdef SHIFT_UP_GRAY_EN
    seq[0] = 4'h1; seq[1] = 4'h3; seq[2] = 4'h2;
`else
    seq[0] = 4'h1; seq[1] = 4'h2; seq[2] = 4'h3;
`endif
    do_reset();
    check("seq0", count_out, 4'h0);
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 4'h0, 1'b0);
      check("seq_step", count_out, seq[k]);
    end

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
